// File: rtl/mem_responder_pkg.sv
// Shared constants for the memory responder: command codes, address-source
// codes and responder state encodings.
package mem_responder_pkg;

    // Memory command codes driven by the decoder; 2'b11 is reserved.
    localparam logic [1:0] MEM_PAUSE = 2'b00;
    localparam logic [1:0] MEM_READ  = 2'b01;
    localparam logic [1:0] MEM_WRITE = 2'b10;

    // Address source select.
    localparam logic ADDR_FROM_PC = 1'b0;
    localparam logic ADDR_FROM_AR = 1'b1;

    // Responder state encodings.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // True for the commands that start a bus transaction.
    function automatic logic is_transfer(input logic [1:0] action);
        return (action == MEM_READ) || (action == MEM_WRITE);
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Memory bus between the responder (master) and the memory (slave).
// Read data is valid in the same cycle as ack.
interface mem_responder_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (output req, we, addr, wdata, input  ack, rdata);
    modport slave  (input  req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/mem_responder_pc_counter.sv
// Program counter: load from i_value, or increment with wrap at 2^ADDR_W.
// A load wins over a same-cycle increment.
module mem_responder_pc_counter #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_value,
    input  logic              i_inc,
    output logic [ADDR_W-1:0] o_pc
);
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_plus1;

    assign w_pc_plus1 = r_pc + ADDR_W'(1);

    // PC register with synchronous reset; load has priority over increment.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else if (i_load) begin
            r_pc <= i_value;
        end else if (i_inc) begin
            r_pc <= w_pc_plus1;
        end
    end

    assign o_pc = r_pc;
endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: owns the PC, selects PC or AR as the address, runs
// a req/ack bus transaction and returns read data with a one-cycle strobe.
// Optional feature: define BB_MEM_TIMEOUT_EN to abort a request that is not
// acknowledged within TIMEOUT cycles (o_err pulses, reads return 0).
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                TIMEOUT  = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        i_mem_action,
    input  logic              i_mem_addr_src,
    input  logic              i_pc_counter_en,
    input  logic              i_pc_load,
    input  logic [ADDR_W-1:0] i_pc_value,
    input  logic [ADDR_W-1:0] i_ar,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [ADDR_W-1:0] o_pc,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_rdata_valid,
    output logic              o_done,
    output logic              o_busy,
    output logic              o_err,
    mem_responder_if.master   bus
);
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("mem_responder: TIMEOUT must be at least 1");
    end

    logic [1:0]        r_state;
    logic              r_we;
    logic              r_inc_on_ack;
    logic [ADDR_W-1:0] r_bus_addr;
    logic [DATA_W-1:0] r_bus_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              w_pc_inc;
    logic [ADDR_W-1:0] w_pc;

`ifdef BB_MEM_TIMEOUT_EN
    localparam int                WAIT_W    = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    logic [WAIT_W-1:0] r_wait;
    logic              r_timeout;
`endif

    // Advance the PC only on the ack edge of a PC-sourced, count-enabled read.
    assign w_pc_inc = (r_state == ST_REQ) && bus.ack && r_inc_on_ack;

    mem_responder_pc_counter #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (i_pc_load),
        .i_value (i_pc_value),
        .i_inc   (w_pc_inc),
        .o_pc    (w_pc)
    );

    // Transaction FSM: accept in IDLE, hold the request until ack, report in RESP.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_we         <= 1'b0;
            r_inc_on_ack <= 1'b0;
            r_bus_addr   <= '0;
            r_bus_wdata  <= '0;
            r_rdata      <= '0;
`ifdef BB_MEM_TIMEOUT_EN
            r_wait       <= '0;
            r_timeout    <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (is_transfer(i_mem_action)) begin
                        r_state      <= ST_REQ;
                        r_we         <= (i_mem_action == MEM_WRITE);
                        r_inc_on_ack <= (i_mem_action == MEM_READ) &&
                                        (i_mem_addr_src == ADDR_FROM_PC) &&
                                        i_pc_counter_en;
                        r_bus_addr   <= (i_mem_addr_src == ADDR_FROM_AR) ? i_ar : w_pc;
                        r_bus_wdata  <= i_wdata;
`ifdef BB_MEM_TIMEOUT_EN
                        r_wait       <= '0;
                        r_timeout    <= 1'b0;
`endif
                    end
                end
                ST_REQ: begin
                    if (bus.ack) begin
                        r_state <= ST_RESP;
                        if (!r_we) begin
                            r_rdata <= bus.rdata;
                        end
`ifdef BB_MEM_TIMEOUT_EN
                    end else if (r_wait == WAIT_LAST) begin
                        r_state   <= ST_RESP;
                        r_timeout <= 1'b1;
                        if (!r_we) begin
                            r_rdata <= '0;
                        end
                    end else begin
                        r_wait <= r_wait + WAIT_W'(1);
`endif
                    end
                end
                ST_RESP: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_pc          = w_pc;
    assign o_rdata       = r_rdata;
    assign o_busy        = (r_state != ST_IDLE);
    assign o_done        = (r_state == ST_RESP);
    assign o_rdata_valid = (r_state == ST_RESP) && !r_we;
`ifdef BB_MEM_TIMEOUT_EN
    assign o_err         = (r_state == ST_RESP) && r_timeout;
`else
    assign o_err         = 1'b0;
`endif

    assign bus.req   = (r_state == ST_REQ);
    assign bus.we    = r_we;
    assign bus.addr  = r_bus_addr;
    assign bus.wdata = r_bus_wdata;
endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: reset state, directed vector table,
// multi-cycle corner sequences and randomized transactions against a
// transaction-level model of PC and read data.
module tb_mem_responder;
    import mem_responder_pkg::*;

    localparam int TIMEOUT = 15;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] i_mem_action;
    logic       i_mem_addr_src;
    logic       i_pc_counter_en;
    logic       i_pc_load;
    logic [7:0] i_pc_value;
    logic [7:0] i_ar;
    logic [7:0] i_wdata;
    logic [7:0] o_pc;
    logic [7:0] o_rdata;
    logic       o_rdata_valid;
    logic       o_done;
    logic       o_busy;
    logic       o_err;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: PC and last returned read data.
    logic [7:0] pc_m;
    logic [7:0] rdata_m;

    mem_responder_if #(.DATA_W(8), .ADDR_W(8)) bus ();

    mem_responder #(
        .DATA_W   (8),
        .ADDR_W   (8),
        .RESET_PC (8'h00),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_mem_action    (i_mem_action),
        .i_mem_addr_src  (i_mem_addr_src),
        .i_pc_counter_en (i_pc_counter_en),
        .i_pc_load       (i_pc_load),
        .i_pc_value      (i_pc_value),
        .i_ar            (i_ar),
        .i_wdata         (i_wdata),
        .o_pc            (o_pc),
        .o_rdata         (o_rdata),
        .o_rdata_valid   (o_rdata_valid),
        .o_done          (o_done),
        .o_busy          (o_busy),
        .o_err           (o_err),
        .bus             (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       preload;
        logic [7:0] pre_val;
        logic [1:0] act;
        logic       src;
        logic       en;
        logic [7:0] ar;
        logic [7:0] wd;
        int         waits;
        logic [7:0] rd;
        logic [7:0] e_addr;
        logic       e_we;
        logic       e_valid;
        logic [7:0] e_rdata;
        logic [7:0] e_pc;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_preload(input logic [7:0] val);
        i_pc_load  = 1'b1;
        i_pc_value = val;
        step();
        i_pc_load  = 1'b0;
        check("preload.pc", o_pc, val);
    endtask

    // One full transaction with a given number of wait cycles before ack.
    // A conflicting READ is held on the command inputs while busy.
    task automatic run_txn(input logic [1:0] act, input logic src, input logic en,
                           input logic [7:0] ar, input logic [7:0] wd, input int waits,
                           input logic [7:0] rd, input logic [7:0] e_addr, input logic e_we,
                           input logic e_valid, input logic [7:0] e_rdata, input logic [7:0] e_pc);
        i_mem_action    = act;
        i_mem_addr_src  = src;
        i_pc_counter_en = en;
        i_ar            = ar;
        i_wdata         = wd;
        step();
        i_mem_action    = MEM_READ;
        i_mem_addr_src  = ADDR_FROM_AR;
        i_ar            = ~ar;
        i_wdata         = ~wd;
        check("txn.req",   bus.req, 1'b1);
        check("txn.busy",  o_busy,  1'b1);
        check("txn.addr",  bus.addr, e_addr);
        check("txn.we",    bus.we,  e_we);
        check("txn.wdata", bus.wdata, wd);
        check("txn.done0", o_done,  1'b0);
        for (int k = 0; k < waits; k++) begin
            step();
            check("wait.req",  bus.req,  1'b1);
            check("wait.addr", bus.addr, e_addr);
            check("wait.done", o_done,   1'b0);
        end
        bus.ack   = 1'b1;
        bus.rdata = rd;
        step();
        bus.ack   = 1'b0;
        bus.rdata = 8'($urandom);
        check("resp.done",  o_done,        1'b1);
        check("resp.valid", o_rdata_valid, e_valid);
        check("resp.err",   o_err,         1'b0);
        check("resp.rdata", o_rdata,       e_rdata);
        check("resp.req",   bus.req,       1'b0);
        check("resp.pc",    o_pc,          e_pc);
        step();
        i_mem_action = MEM_PAUSE;
        check("idle.busy",  o_busy,        1'b0);
        check("idle.done",  o_done,        1'b0);
        check("idle.valid", o_rdata_valid, 1'b0);
        check("idle.req",   bus.req,       1'b0);
        check("idle.rdata", o_rdata,       e_rdata);
    endtask

    initial begin
        vecs[0] = '{1'b0, 8'h00, MEM_READ,  ADDR_FROM_PC, 1'b1, 8'h12, 8'h00, 0, 8'hA5, 8'h00, 1'b0, 1'b1, 8'hA5, 8'h01};
        vecs[1] = '{1'b0, 8'h00, MEM_WRITE, ADDR_FROM_AR, 1'b0, 8'h40, 8'h3C, 3, 8'hEE, 8'h40, 1'b1, 1'b0, 8'hA5, 8'h01};
        vecs[2] = '{1'b0, 8'h00, MEM_READ,  ADDR_FROM_AR, 1'b1, 8'h77, 8'h00, 1, 8'h5A, 8'h77, 1'b0, 1'b1, 8'h5A, 8'h01};
        vecs[3] = '{1'b0, 8'h00, MEM_READ,  ADDR_FROM_PC, 1'b0, 8'h00, 8'h00, 2, 8'h11, 8'h01, 1'b0, 1'b1, 8'h11, 8'h01};
        vecs[4] = '{1'b1, 8'hFF, MEM_READ,  ADDR_FROM_PC, 1'b1, 8'h00, 8'h00, 0, 8'h22, 8'hFF, 1'b0, 1'b1, 8'h22, 8'h00};
        vecs[5] = '{1'b0, 8'h00, MEM_WRITE, ADDR_FROM_PC, 1'b1, 8'h00, 8'h99, 1, 8'h00, 8'h00, 1'b1, 1'b0, 8'h22, 8'h00};
        vecs[6] = '{1'b0, 8'h00, MEM_READ,  ADDR_FROM_PC, 1'b1, 8'h55, 8'h00, 2, 8'hC3, 8'h00, 1'b0, 1'b1, 8'hC3, 8'h01};

        rst_n           = 1'b0;
        i_mem_action    = MEM_PAUSE;
        i_mem_addr_src  = ADDR_FROM_PC;
        i_pc_counter_en = 1'b0;
        i_pc_load       = 1'b0;
        i_pc_value      = 8'h00;
        i_ar            = 8'h00;
        i_wdata         = 8'h00;
        bus.ack         = 1'b0;
        bus.rdata       = 8'h00;
        repeat (3) step();
        rst_n = 1'b1;

        // Reset state.
        check("rst.pc",    o_pc,          8'h00);
        check("rst.rdata", o_rdata,       8'h00);
        check("rst.valid", o_rdata_valid, 1'b0);
        check("rst.done",  o_done,        1'b0);
        check("rst.busy",  o_busy,        1'b0);
        check("rst.err",   o_err,         1'b0);
        check("rst.req",   bus.req,       1'b0);
        check("rst.we",    bus.we,        1'b0);
        check("rst.addr",  bus.addr,      8'h00);
        check("rst.wdata", bus.wdata,     8'h00);

        // PAUSE and reserved code start nothing; ack while idle is ignored.
        i_mem_action = MEM_PAUSE;
        step();
        check("pause.busy", o_busy, 1'b0);
        i_mem_action = 2'b11;
        bus.ack      = 1'b1;
        bus.rdata    = 8'h66;
        repeat (3) begin
            step();
            check("rsvd.busy",  o_busy,  1'b0);
            check("rsvd.req",   bus.req, 1'b0);
            check("rsvd.done",  o_done,  1'b0);
            check("rsvd.rdata", o_rdata, 8'h00);
        end
        bus.ack      = 1'b0;
        i_mem_action = MEM_PAUSE;

        // Directed vector table.
        for (int v = 0; v < 7; v++) begin
            if (vecs[v].preload) do_preload(vecs[v].pre_val);
            run_txn(vecs[v].act, vecs[v].src, vecs[v].en, vecs[v].ar, vecs[v].wd,
                    vecs[v].waits, vecs[v].rd, vecs[v].e_addr, vecs[v].e_we,
                    vecs[v].e_valid, vecs[v].e_rdata, vecs[v].e_pc);
        end
        pc_m    = 8'h01;
        rdata_m = 8'hC3;

        // pc_load during REQ leaves the in-flight address alone; a load on the
        // ack edge wins over the increment.
        i_mem_action    = MEM_READ;
        i_mem_addr_src  = ADDR_FROM_PC;
        i_pc_counter_en = 1'b1;
        step();
        i_mem_action = MEM_PAUSE;
        check("ld.addr0", bus.addr, pc_m);
        i_pc_load  = 1'b1;
        i_pc_value = 8'h30;
        step();
        check("ld.pc_req",  o_pc,     8'h30);
        check("ld.addr1",   bus.addr, pc_m);
        check("ld.req",     bus.req,  1'b1);
        i_pc_value = 8'h80;
        bus.ack    = 1'b1;
        bus.rdata  = 8'h4B;
        step();
        i_pc_load = 1'b0;
        bus.ack   = 1'b0;
        check("ld.pc_win", o_pc,    8'h80);
        check("ld.done",   o_done,  1'b1);
        check("ld.rdata",  o_rdata, 8'h4B);
        step();
        pc_m    = 8'h80;
        rdata_m = 8'h4B;

        // Reset during REQ: request drops, no done, PC back to reset value.
        i_mem_action = MEM_READ;
        step();
        i_mem_action = MEM_PAUSE;
        check("mrst.req1", bus.req, 1'b1);
        rst_n = 1'b0;
        step();
        check("mrst.req",  bus.req, 1'b0);
        check("mrst.busy", o_busy,  1'b0);
        check("mrst.done", o_done,  1'b0);
        check("mrst.pc",   o_pc,    8'h00);
        rst_n   = 1'b1;
        bus.ack = 1'b1;
        step();
        bus.ack = 1'b0;
        check("mrst.done2",  o_done,        1'b0);
        check("mrst.valid2", o_rdata_valid, 1'b0);
        check("mrst.rdata",  o_rdata,       8'h00);
        pc_m    = 8'h00;
        rdata_m = 8'h00;
        run_txn(MEM_READ, ADDR_FROM_PC, 1'b1, 8'h00, 8'h00, 1, 8'h9D, 8'h00, 1'b0, 1'b1, 8'h9D, 8'h01);
        pc_m    = 8'h01;
        rdata_m = 8'h9D;

`ifdef BB_MEM_TIMEOUT_EN
        // No ack: request held TIMEOUT cycles, then error response with zero data.
        begin
            int n_req = 0;
            i_mem_action = MEM_READ;
            i_mem_addr_src = ADDR_FROM_PC;
            i_pc_counter_en = 1'b1;
            step();
            i_mem_action = MEM_PAUSE;
            while (bus.req && n_req < 40) begin
                n_req++;
                step();
            end
            check("to.cycles", n_req,         TIMEOUT);
            check("to.err",    o_err,         1'b1);
            check("to.done",   o_done,        1'b1);
            check("to.valid",  o_rdata_valid, 1'b1);
            check("to.rdata",  o_rdata,       8'h00);
            check("to.pc",     o_pc,          pc_m);
            step();
            check("to.err_off", o_err, 1'b0);
            rdata_m = 8'h00;
        end
`endif

        // Randomized transactions against the transaction-level model.
        for (int it = 0; it < 80; it++) begin
            logic [1:0] act;
            logic       src, en;
            logic [7:0] ar, wd, rd, e_addr;
            int         waits;
            act   = 2'($urandom_range(0, 3));
            src   = 1'($urandom);
            en    = 1'($urandom);
            ar    = 8'($urandom);
            wd    = 8'($urandom);
            rd    = 8'($urandom);
            waits = $urandom_range(0, 4);
            if ($urandom_range(0, 3) == 0) begin
                pc_m = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom);
                do_preload(pc_m);
            end
            if (act == MEM_READ || act == MEM_WRITE) begin
                e_addr = src ? ar : pc_m;
                if (act == MEM_READ) begin
                    rdata_m = rd;
                    if (!src && en) pc_m = pc_m + 8'd1;
                end
                run_txn(act, src, en, ar, wd, waits, rd, e_addr, act == MEM_WRITE,
                        act == MEM_READ, rdata_m, pc_m);
            end else begin
                i_mem_action = act;
                step();
                i_mem_action = MEM_PAUSE;
                check("rnd.pause.busy", o_busy, 1'b0);
                check("rnd.pause.pc",   o_pc,   pc_m);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
